rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Sequences the single write port of the 31x32 register file (x0 hardwired 0, write on posedge, read on negedge).
//  Arbitrates two writeback sources (ALU "A", load unit "M") onto WNUM/WDATA with valid/ready handshakes.
//  Holds a pending-write scoreboard: decode issues a destination, writeback retires it, HAZ1/HAZ2 flag RAW hazards.
//  Sits between decode/EX/MEM writeback and the RF write port; drives the stall input of the decode stage.
// PARAMETERS
//  XLEN    32  data width of WDATA paths
//  RR_EN   1   1 = round-robin between A and M; 0 = fixed priority, M wins
// PORTS
//  CLK         in   1     clock, all state on posedge
//  RST_N       in   1     asynchronous active-low reset
//  ISSUE_VALID in   1     decode wants to reserve destination ISSUE_WNUM
//  ISSUE_WNUM  in   5     destination register of issuing instruction
//  ISSUE_READY out  1     reservation accepted this cycle
//  A_VALID     in   1     ALU writeback request
//  A_WNUM      in   5     ALU destination
//  A_WDATA     in   XLEN  ALU result
//  A_READY     out  1     ALU request granted this cycle
//  M_VALID     in   1     load writeback request
//  M_WNUM      in   5     load destination
//  M_WDATA     in   XLEN  load data
//  M_READY     out  1     load request granted this cycle
//  RNUM1       in   5     decode source 1 (same value driven to RF RNUM1)
//  RNUM2       in   5     decode source 2
//  HAZ1, HAZ2  out  1     source 1/2 has a pending write (combinational)
//  WNUM        out  5     to RF WNUM, registered; 0 = no write
//  WDATA       out  XLEN  to RF WDATA, registered
// BEHAVIOUR
//  Reset (RST_N low, any time): WNUM=0, WDATA=0, PEND[31:1]=0, RR pointer -> A preferred; READY outputs follow from state.
//  Port stage: each posedge, WNUM/WDATA <= granted request, else WNUM <= 0 (WDATA holds). RF commits it next posedge.
//  Latency: grant at edge N -> WNUM valid after N -> RF write at edge N+1 -> readable at negedge after N+1.
//  Arbitration (comb): one grant per cycle. Only one valid -> it is granted. Both valid: RR_EN=1 grants side not
//   granted last (pointer updates only on a two-way conflict); RR_EN=0 grants M. READY is combinational, may depend on VALID.
//  Request with WNUM=0: granted normally, WNUM output 0, no scoreboard effect (dropped write).
//  Scoreboard PEND[31:1]: set on ISSUE_VALID&&ISSUE_READY&&ISSUE_WNUM!=0; cleared at the posedge where output WNUM==k
//   (RF commit edge). Set and clear of same k at one edge -> bit stays set.
//  ISSUE_READY = !PEND[ISSUE_WNUM] || (WNUM==ISSUE_WNUM); always 1 for ISSUE_WNUM=0. One outstanding write per register,
//   so A and M never target the same nonzero register concurrently; no ordering check between them.
//  HAZk = RNUMk!=0 && PEND[RNUMk] (includes in-flight WNUM register not yet committed).
//  Request for a register with PEND clear is a protocol error: written to RF anyway, PEND untouched; assertion in sim.
//  VALID/WNUM/WDATA must stay stable while VALID && !READY (source-side rule; checked by bench assertion).
// TESTING
//  Reset: drive RST_N=0 mid-run with WNUM=7 pending -> WNUM=0, PEND=0, HAZ1=0 immediately, no RF write follows.
//  Single write: issue x5, A_VALID A_WNUM=5 A_WDATA=0xDEADBEEF -> A_READY=1, WNUM=5 next cycle, RF x5=0xDEADBEEF, HAZ1(RNUM1=5) drops same edge.
//  Conflict, RR_EN=1: A and M both valid 3 cycles (x1,x2 then x3,x4) -> grants M? no: A,M,A order, WNUM sequence 1,2,3.
//  Conflict, RR_EN=0: both valid -> M granted every cycle until M_VALID drops, A waits with A_READY=0.
//  Reissue: x9 pending, ISSUE x9 -> ISSUE_READY=0; in cycle WNUM=9 ISSUE x9 -> accepted, PEND[9] remains 1.
//  x0: A_WNUM=0 A_WDATA=0xFFFFFFFF -> A_READY=1, WNUM stays 0, RF read of x0 returns 0, HAZ1(RNUM1=0)=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto the register-file write port and tracks pending destination writes.
// Latency: grant -> WNUM/WDATA registered at next edge -> RF commit one edge later; READY/HAZ are combinational.
// Backpressure: the conflict loser sees ready=0 and must hold; issue stalls while its destination is still pending.
module rf_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [4:0]      issue_wnum,
    output logic            issue_ready,
    input  logic            a_valid,
    input  logic [4:0]      a_wnum,
    input  logic [XLEN-1:0] a_wdata,
    output logic            a_ready,
    input  logic            m_valid,
    input  logic [4:0]      m_wnum,
    input  logic [XLEN-1:0] m_wdata,
    output logic            m_ready,
    input  logic [4:0]      rnum1,
    input  logic [4:0]      rnum2,
    output logic            haz1,
    output logic            haz2,
    output logic [4:0]      wnum,
    output logic [XLEN-1:0] wdata
);

    // Bit 0 is kept permanently clear so x0 never reads as pending.
    logic [31:0]     pend;
    logic [31:0]     pend_next;
    logic            pref_m;
    logic            grant_a;
    logic            grant_m;
    logic [4:0]      gnt_wnum;
    logic [XLEN-1:0] gnt_wdata;

    always_comb begin
        grant_m   = m_valid && (!a_valid || !RR_EN || pref_m);
        grant_a   = a_valid && !grant_m;
        a_ready   = grant_a;
        m_ready   = grant_m;
        gnt_wnum  = grant_m ? m_wnum  : a_wnum;
        gnt_wdata = grant_m ? m_wdata : a_wdata;
    end

    // A register whose write is committing this edge may be re-reserved in the same cycle.
    assign issue_ready = (issue_wnum == 5'd0) || !pend[issue_wnum] || (wnum == issue_wnum);

    assign haz1 = (rnum1 != 5'd0) && pend[rnum1];
    assign haz2 = (rnum2 != 5'd0) && pend[rnum2];

    // Clear for the committing register first so a same-edge reissue leaves the bit set.
    always_comb begin
        pend_next = pend & ~(32'd1 << wnum);
        if (issue_valid && issue_ready && (issue_wnum != 5'd0)) begin
            pend_next[issue_wnum] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wnum   <= '0;
            wdata  <= '0;
            pend   <= '0;
            pref_m <= 1'b0;
        end else begin
            pend <= pend_next;
            if (grant_a || grant_m) begin
                wnum  <= gnt_wnum;
                wdata <= gnt_wdata;
            end else begin
                wnum <= '0;
            end
            // Pointer moves only on a two-way conflict, toward the side that lost.
            if (a_valid && m_valid) begin
                pref_m <= grant_a;
            end
        end
    end

    wb_target_pending: assert property (@(posedge clk) disable iff (!rst_n)
        ((grant_a || grant_m) && (gnt_wnum != 5'd0)) |-> pend[gnt_wnum]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios on a round-robin and a fixed-priority instance, then randomized traffic.
module tb_rf_wb_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            issue_valid, issue_ready;
    logic [4:0]      issue_wnum;
    logic            a_valid, a_ready, m_valid, m_ready;
    logic [4:0]      a_wnum, m_wnum;
    logic [XLEN-1:0] a_wdata, m_wdata;
    logic [4:0]      rnum1, rnum2;
    logic            haz1, haz2;
    logic [4:0]      wnum;
    logic [XLEN-1:0] wdata;

    logic            f_issue_valid, f_issue_ready;
    logic [4:0]      f_issue_wnum;
    logic            f_a_valid, f_a_ready, f_m_valid, f_m_ready;
    logic [4:0]      f_a_wnum, f_m_wnum;
    logic [XLEN-1:0] f_a_wdata, f_m_wdata;
    logic [4:0]      f_rnum1, f_rnum2;
    logic            f_haz1, f_haz2;
    logic [4:0]      f_wnum;
    logic [XLEN-1:0] f_wdata;

    rf_wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wnum(issue_wnum), .issue_ready(issue_ready),
        .a_valid(a_valid), .a_wnum(a_wnum), .a_wdata(a_wdata), .a_ready(a_ready),
        .m_valid(m_valid), .m_wnum(m_wnum), .m_wdata(m_wdata), .m_ready(m_ready),
        .rnum1(rnum1), .rnum2(rnum2), .haz1(haz1), .haz2(haz2),
        .wnum(wnum), .wdata(wdata)
    );

    rf_wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(f_issue_valid), .issue_wnum(f_issue_wnum), .issue_ready(f_issue_ready),
        .a_valid(f_a_valid), .a_wnum(f_a_wnum), .a_wdata(f_a_wdata), .a_ready(f_a_ready),
        .m_valid(f_m_valid), .m_wnum(f_m_wnum), .m_wdata(f_m_wdata), .m_ready(f_m_ready),
        .rnum1(f_rnum1), .rnum2(f_rnum2), .haz1(f_haz1), .haz2(f_haz2),
        .wnum(f_wnum), .wdata(f_wdata)
    );

    // Register file attached to the write port: commits on posedge.
    logic [31:0] rf [32] = '{default: 32'd0};
    always @(posedge clk) if (wnum != 5'd0) rf[wnum] <= wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (a_valid && !a_ready) |=> (a_valid && $stable(a_wnum) && $stable(a_wdata)))
        else begin errors++; $error("FAIL a_hold source changed while stalled"); end
    m_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_wnum) && $stable(m_wdata)))
        else begin errors++; $error("FAIL m_hold source changed while stalled"); end

    // Reference model state for the randomized phase
    bit              mp    [32];
    bit              owed  [32];
    int              mw;
    logic [XLEN-1:0] md;
    bit              pref_m;

    initial begin
        int r;
        bit ega, egm, eir, got_a, got_m;
        int nmw;
        logic [XLEN-1:0] nmd;

        rst_n = 1'b0;
        issue_valid = 0; issue_wnum = 0; a_valid = 0; a_wnum = 0; a_wdata = 0;
        m_valid = 0; m_wnum = 0; m_wdata = 0; rnum1 = 5; rnum2 = 0;
        f_issue_valid = 0; f_issue_wnum = 0; f_a_valid = 0; f_a_wnum = 0; f_a_wdata = 0;
        f_m_valid = 0; f_m_wnum = 0; f_m_wdata = 0; f_rnum1 = 0; f_rnum2 = 0;
        issue_wnum = 5;
        tick();
        check("rst_wnum", wnum, 0);
        check("rst_wdata", wdata, 0);
        check("rst_haz1", haz1, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_a_ready", a_ready, 0);
        tick();
        rst_n = 1'b1;

        // Single write to x5
        issue_valid = 1; issue_wnum = 5;
        #2 check("x5_issue_ready", issue_ready, 1);
        tick();
        issue_valid = 0; rnum1 = 5;
        a_valid = 1; a_wnum = 5; a_wdata = 32'hDEADBEEF;
        #2 check("x5_haz1_pending", haz1, 1);
        check("x5_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        check("x5_wnum", wnum, 5);
        check("x5_wdata", wdata, 32'hDEADBEEF);
        check("x5_haz1_inflight", haz1, 1);
        tick();
        check("x5_wnum_clear", wnum, 0);
        check("x5_haz1_drop", haz1, 0);
        check("x5_rf", rf[5], 32'hDEADBEEF);

        // Round-robin conflict: A x1 then x3, M x2 then x4
        for (int k = 1; k <= 4; k++) begin
            issue_valid = 1; issue_wnum = 5'(k);
            tick();
        end
        issue_valid = 0;
        a_valid = 1; a_wnum = 1; a_wdata = 32'h11;
        m_valid = 1; m_wnum = 2; m_wdata = 32'h22;
        #2 check("rr1_a_ready", a_ready, 1);
        check("rr1_m_ready", m_ready, 0);
        tick();
        a_wnum = 3; a_wdata = 32'h33;
        check("rr1_wnum", wnum, 1);
        #2 check("rr2_a_ready", a_ready, 0);
        check("rr2_m_ready", m_ready, 1);
        tick();
        m_wnum = 4; m_wdata = 32'h44;
        check("rr2_wnum", wnum, 2);
        check("rr2_wdata", wdata, 32'h22);
        #2 check("rr3_a_ready", a_ready, 1);
        check("rr3_m_ready", m_ready, 0);
        tick();
        a_valid = 0;
        check("rr3_wnum", wnum, 3);
        #2 check("rr4_m_ready", m_ready, 1);
        tick();
        m_valid = 0;
        check("rr4_wnum", wnum, 4);
        tick();

        // Fixed priority: M wins every conflict until it drops
        for (int k = 10; k <= 12; k++) begin
            f_issue_valid = 1; f_issue_wnum = 5'(k);
            #2 check("fx_issue_ready", f_issue_ready, 1);
            tick();
        end
        f_issue_valid = 0; f_rnum1 = 10; f_rnum2 = 12;
        f_m_valid = 1; f_m_wnum = 10; f_m_wdata = 32'hA0;
        f_a_valid = 1; f_a_wnum = 12; f_a_wdata = 32'hC0;
        #2 check("fx1_haz1", f_haz1, 1);
        check("fx1_m_ready", f_m_ready, 1);
        check("fx1_a_ready", f_a_ready, 0);
        tick();
        f_m_wnum = 11; f_m_wdata = 32'hB0;
        check("fx1_wnum", f_wnum, 10);
        #2 check("fx2_m_ready", f_m_ready, 1);
        check("fx2_a_ready", f_a_ready, 0);
        tick();
        f_m_valid = 0;
        check("fx2_wnum", f_wnum, 11);
        #2 check("fx3_a_ready", f_a_ready, 1);
        tick();
        f_a_valid = 0;
        check("fx3_wnum", f_wnum, 12);
        check("fx3_wdata", f_wdata, 32'hC0);
        check("fx3_haz2_inflight", f_haz2, 1);
        tick();
        check("fx4_haz2_drop", f_haz2, 0);

        // Reissue of x9 only in the cycle its write commits
        issue_valid = 1; issue_wnum = 9;
        tick();
        #2 check("re_issue_blocked", issue_ready, 0);
        a_valid = 1; a_wnum = 9; a_wdata = 32'h99;
        tick();
        a_valid = 0;
        check("re_wnum", wnum, 9);
        check("re_issue_commit", issue_ready, 1);
        tick();
        issue_valid = 0; rnum1 = 9;
        #2 check("re_haz1_kept", haz1, 1);
        issue_valid = 1;
        #1 check("re_issue_blocked2", issue_ready, 0);
        issue_valid = 0;
        a_valid = 1; a_wnum = 9; a_wdata = 32'h999;
        tick();
        a_valid = 0;
        tick();
        check("re_haz1_retired", haz1, 0);
        check("re_rf9", rf[9], 32'h999);

        // Dropped write to x0
        issue_valid = 1; issue_wnum = 6;
        tick();
        issue_valid = 0;
        a_valid = 1; a_wnum = 0; a_wdata = 32'hFFFFFFFF; rnum1 = 0; rnum2 = 6;
        #2 check("x0_a_ready", a_ready, 1);
        check("x0_haz1", haz1, 0);
        tick();
        a_valid = 0;
        check("x0_wnum", wnum, 0);
        check("x0_wdata", wdata, 32'hFFFFFFFF);
        tick();
        check("x0_wdata_hold", wdata, 32'hFFFFFFFF);
        check("x0_haz2_x6_kept", haz2, 1);
        a_valid = 1; a_wnum = 6; a_wdata = 32'h66;
        tick();
        a_valid = 0;
        tick();

        // Reset mid-run with x7 in flight
        issue_valid = 1; issue_wnum = 7;
        tick();
        issue_valid = 0; rnum1 = 7;
        a_valid = 1; a_wnum = 7; a_wdata = 32'h77;
        tick();
        a_valid = 0;
        check("mr_wnum", wnum, 7);
        #2 rst_n = 1'b0;
        #1 check("mr_wnum_rst", wnum, 0);
        check("mr_wdata_rst", wdata, 0);
        check("mr_haz1_rst", haz1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_rf7_untouched", rf[7], 0);
        issue_wnum = 7;
        #1 check("mr_issue_ready", issue_ready, 1);

        // Randomized traffic against the reference model
        mw = 0; md = '0; pref_m = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!a_valid && ($urandom_range(0, 1) == 1)) begin
                r = $urandom_range(0, 7);
                if (r == 0 || owed[r]) begin
                    a_valid = 1; a_wnum = 5'(r); a_wdata = $urandom;
                    owed[r] = 0;
                end
            end
            if (!m_valid && ($urandom_range(0, 1) == 1)) begin
                r = $urandom_range(0, 7);
                if (r == 0 || owed[r]) begin
                    m_valid = 1; m_wnum = 5'(r); m_wdata = $urandom;
                    owed[r] = 0;
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_wnum  = 5'($urandom_range(0, 7));
            rnum1       = 5'($urandom_range(0, 7));
            rnum2       = 5'($urandom_range(0, 7));
            #2;
            eir = (issue_wnum == 0) || !mp[issue_wnum] || (mw == int'(issue_wnum));
            ega = a_valid && (!m_valid || !pref_m);
            egm = m_valid && !ega;
            check("rnd_issue_ready", issue_ready, eir);
            check("rnd_a_ready", a_ready, ega);
            check("rnd_m_ready", m_ready, egm);
            check("rnd_haz1", haz1, (rnum1 != 0) && mp[rnum1]);
            check("rnd_haz2", haz2, (rnum2 != 0) && mp[rnum2]);
            got_a = a_ready;
            got_m = m_ready;

            nmw = egm ? int'(m_wnum) : (ega ? int'(a_wnum) : 0);
            nmd = egm ? m_wdata : (ega ? a_wdata : md);
            if (mw != 0) mp[mw] = 0;
            if (issue_valid && eir && issue_wnum != 0) begin
                mp[issue_wnum]   = 1;
                owed[issue_wnum] = 1;
            end
            if (a_valid && m_valid) pref_m = ega;

            tick();
            if (got_a) a_valid = 0;
            if (got_m) m_valid = 0;
            check("rnd_wnum", wnum, 5'(nmw));
            check("rnd_wdata", wdata, nmd);
            mw = nmw;
            md = nmd;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
